// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the pipeline-side request/response signals of the instruction
//   and data ports together with the backend request/response channel.
//
//   Ports (all signals, names as seen by the arbiter):
//     i_instr_req_en / i_instr_req_addr          fetch request
//     o_instr_res_data / o_instr_res_code        fetch response
//     i_mem_req_en / _addr / _wr_data / _wr_en / _count   data request
//     o_mem_res_rd_data / o_mem_res_code         data response
//     o_bk_req_valid / i_bk_req_ready / o_bk_req_*         backend request
//     i_bk_res_valid / i_bk_res_data / i_bk_res_err        backend response
//
//   Backend request handshake: a request transfers on a rising edge where
//   o_bk_req_valid and i_bk_req_ready are both 1. While valid is 1 and ready
//   is 0 the o_bk_req_* fields are held stable. Valid never depends on ready.
//   i_bk_res_valid is a single-cycle strobe with no back-pressure.
//
//   Modports: master = the arbiter, slave = pipeline + backend environment.
interface mem_port_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int COUNT_W = 2
);
    logic               i_instr_req_en;
    logic [ADDR_W-1:0]  i_instr_req_addr;
    logic [WORD_W-1:0]  o_instr_res_data;
    logic [1:0]         o_instr_res_code;

    logic               i_mem_req_en;
    logic [ADDR_W-1:0]  i_mem_req_addr;
    logic [WORD_W-1:0]  i_mem_req_wr_data;
    logic               i_mem_req_wr_en;
    logic [COUNT_W-1:0] i_mem_req_count;
    logic [WORD_W-1:0]  o_mem_res_rd_data;
    logic [1:0]         o_mem_res_code;

    logic               o_bk_req_valid;
    logic               i_bk_req_ready;
    logic [ADDR_W-1:0]  o_bk_req_addr;
    logic [WORD_W-1:0]  o_bk_req_wr_data;
    logic               o_bk_req_wr_en;
    logic [COUNT_W-1:0] o_bk_req_count;
    logic               i_bk_res_valid;
    logic [WORD_W-1:0]  i_bk_res_data;
    logic               i_bk_res_err;

    modport master (
        input  i_instr_req_en, i_instr_req_addr,
        input  i_mem_req_en, i_mem_req_addr, i_mem_req_wr_data,
        input  i_mem_req_wr_en, i_mem_req_count,
        input  i_bk_req_ready, i_bk_res_valid, i_bk_res_data, i_bk_res_err,
        output o_instr_res_data, o_instr_res_code,
        output o_mem_res_rd_data, o_mem_res_code,
        output o_bk_req_valid, o_bk_req_addr, o_bk_req_wr_data,
        output o_bk_req_wr_en, o_bk_req_count
    );

    modport slave (
        output i_instr_req_en, i_instr_req_addr,
        output i_mem_req_en, i_mem_req_addr, i_mem_req_wr_data,
        output i_mem_req_wr_en, i_mem_req_count,
        output i_bk_req_ready, i_bk_res_valid, i_bk_res_data, i_bk_res_err,
        input  o_instr_res_data, o_instr_res_code,
        input  o_mem_res_rd_data, o_mem_res_code,
        input  o_bk_req_valid, o_bk_req_addr, o_bk_req_wr_data,
        input  o_bk_req_wr_en, o_bk_req_count
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port backing memory between the instruction-fetch
//   port and the data port. Data wins contention unless the instruction
//   port has lost STARVE_LIMIT contended grants in a row. One transaction
//   is in flight at a time; a backend that does not answer within TIMEOUT
//   cycles of ISSUE+WAIT produces an ERR response with zero data.
//
//   Ports:
//     clk, reset      clock and synchronous active-high reset
//     bus             mem_port_arbiter_if master modport (all request,
//                     response and backend signals)
//     dbg_state       current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//     dbg_starve_cnt  current starvation counter
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int WORD_W       = 32,
    parameter int COUNT_W      = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    mem_port_arbiter_if.master                 bus,
    output logic [1:0]                         dbg_state,
    output logic [$clog2(STARVE_LIMIT+1)-1:0]  dbg_starve_cnt
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] G_NONE  = 2'd0;
    localparam logic [1:0] G_INSTR = 2'd1;
    localparam logic [1:0] G_DATA  = 2'd2;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_BUSY = 2'd1;
    localparam logic [1:0] RES_OK   = 2'd2;
    localparam logic [1:0] RES_ERR  = 2'd3;

    logic [1:0]         state;
    logic [1:0]         grant;
    logic [SC_W-1:0]    starve_cnt;
    logic [TO_W-1:0]    timeout_cnt;
    logic               resp_err;
    logic [ADDR_W-1:0]  req_addr;
    logic [WORD_W-1:0]  req_wr_data;
    logic               req_wr_en;
    logic [COUNT_W-1:0] req_count;
    logic [WORD_W-1:0]  instr_data;
    logic [WORD_W-1:0]  mem_data;

    logic pick_instr;
    logic pick_data;
    logic in_flight;
    logic deadline;
    logic complete;

    always_comb begin
        // Instruction port only wins contention once it has been starved.
        pick_instr = bus.i_instr_req_en &&
                     (!bus.i_mem_req_en || starve_cnt == SC_W'(STARVE_LIMIT));
        pick_data  = bus.i_mem_req_en && !pick_instr;
        in_flight  = (state == S_ISSUE) || (state == S_WAIT);
        deadline   = timeout_cnt == TO_W'(TIMEOUT - 1);
        // A response counts in ISSUE only if it lands with the acceptance.
        complete   = bus.i_bk_res_valid &&
                     ((state == S_WAIT) || (state == S_ISSUE && bus.i_bk_req_ready));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            grant       <= G_NONE;
            starve_cnt  <= '0;
            timeout_cnt <= '0;
            resp_err    <= 1'b0;
            req_addr    <= '0;
            req_wr_data <= '0;
            req_wr_en   <= 1'b0;
            req_count   <= '0;
            instr_data  <= '0;
            mem_data    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_instr) begin
                        grant       <= G_INSTR;
                        req_addr    <= bus.i_instr_req_addr;
                        req_wr_data <= '0;
                        req_wr_en   <= 1'b0;
                        req_count   <= COUNT_W'(2);
                        starve_cnt  <= '0;
                        timeout_cnt <= '0;
                        state       <= S_ISSUE;
                    end else if (pick_data) begin
                        grant       <= G_DATA;
                        req_addr    <= bus.i_mem_req_addr;
                        req_wr_data <= bus.i_mem_req_wr_data;
                        req_wr_en   <= bus.i_mem_req_wr_en;
                        req_count   <= bus.i_mem_req_count;
                        if (bus.i_instr_req_en && starve_cnt != SC_W'(STARVE_LIMIT))
                            starve_cnt <= starve_cnt + SC_W'(1);
                        timeout_cnt <= '0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    timeout_cnt <= timeout_cnt + TO_W'(1);
                    if (complete) begin
                        resp_err <= bus.i_bk_res_err;
                        if (grant == G_INSTR) instr_data <= bus.i_bk_res_data;
                        else                  mem_data   <= bus.i_bk_res_data;
                        state <= S_RESP;
                    end else if (deadline) begin
                        resp_err <= 1'b1;
                        if (grant == G_INSTR) instr_data <= '0;
                        else                  mem_data   <= '0;
                        state <= S_RESP;
                    end else if (state == S_ISSUE && bus.i_bk_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                default: begin
                    grant <= G_NONE;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    logic [1:0] instr_code;
    logic [1:0] mem_code;

    always_comb begin
        instr_code = bus.i_instr_req_en ? RES_BUSY : RES_NONE;
        mem_code   = bus.i_mem_req_en   ? RES_BUSY : RES_NONE;
        if (grant == G_INSTR) begin
            if (in_flight)            instr_code = RES_BUSY;
            else if (state == S_RESP) instr_code = resp_err ? RES_ERR : RES_OK;
        end
        if (grant == G_DATA) begin
            if (in_flight)            mem_code = RES_BUSY;
            else if (state == S_RESP) mem_code = resp_err ? RES_ERR : RES_OK;
        end
    end

    assign bus.o_instr_res_data  = instr_data;
    assign bus.o_instr_res_code  = instr_code;
    assign bus.o_mem_res_rd_data = mem_data;
    assign bus.o_mem_res_code    = mem_code;
    assign bus.o_bk_req_valid    = (state == S_ISSUE);
    assign bus.o_bk_req_addr     = req_addr;
    assign bus.o_bk_req_wr_data  = req_wr_data;
    assign bus.o_bk_req_wr_en    = req_wr_en;
    assign bus.o_bk_req_count    = req_count;
    assign dbg_state             = state;
    assign dbg_starve_cnt        = starve_cnt;
endmodule
